// File: rtl/alu_issue_ctrl.sv
// Issue controller for the alu block: 8-entry register file, one instruction in flight.
// Defining ALU_ISSUE_PERF_EN adds saturating PERF_OPS/PERF_ERR completion counters.
module alu_issue_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [12:0]      INSTR,
    input  logic             LD_EN,
    input  logic [2:0]       LD_ADDR,
    input  logic [WIDTH-1:0] LD_DATA,
    input  logic [2:0]       RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_RES,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF,
    output logic             DONE,
    output logic             ERR,
    output logic [3:0]       FLAGS,
    output logic             BUSY
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]      PERF_OPS,
    output logic [15:0]      PERF_ERR
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       dst;
    logic [WIDTH-1:0] rf [8];

    logic [3:0] in_op;
    logic [2:0] in_dst;
    logic [2:0] in_srca;
    logic [2:0] in_srcb;
    logic       in_legal;

    assign in_op    = INSTR[12:9];
    assign in_dst   = INSTR[8:6];
    assign in_srca  = INSTR[5:3];
    assign in_srcb  = INSTR[2:0];
    assign in_legal = (in_op >= 4'd2) && (in_op <= 4'd7);

    // A pending register-file load blocks acceptance for that cycle.
    assign IN_READY = (state == S_IDLE) && !LD_EN;
    assign BUSY     = (state != S_IDLE);
    assign RD_DATA  = rf[RD_ADDR];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            dst        <= '0;
            ALU_EN     <= 1'b0;
            ALU_OE     <= 1'b0;
            ALU_OPCODE <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            FLAGS      <= '0;
            // NOTE: the register file is cleared on reset because software relies on every
            // entry reading zero afterwards; that makes it flops rather than an inferred RAM.
            for (int i = 0; i < 8; i++) begin
                rf[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so the operand capture at accept
            // reads the register file as it stood before this edge.
            unique case (state)
                S_IDLE: begin
                    if (LD_EN) begin
                        rf[LD_ADDR] <= LD_DATA;
                    end else if (IN_VALID) begin
                        ALU_OPCODE <= in_op;
                        dst        <= in_dst;
                        ALU_A      <= rf[in_srca];
                        ALU_B      <= rf[in_srcb];
                        if (in_legal) begin
                            state  <= S_ISSUE;
                            ALU_EN <= 1'b1;
                            ALU_OE <= 1'b1;
                        end else begin
                            state <= S_WB;
                            DONE  <= 1'b1;
                            ERR   <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    ALU_EN   <= 1'b0;
                    wait_cnt <= CNT_W'(ALU_LAT);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= S_WB;
                        DONE  <= 1'b1;
                    end
                end
                S_WB: begin
                    // ERR is still high here only for an illegal opcode.
                    if (!ERR) begin
                        rf[dst] <= ALU_RES;
                        FLAGS   <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
                    end
                    DONE   <= 1'b0;
                    ERR    <= 1'b0;
                    ALU_OE <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PERF_OPS <= '0;
            PERF_ERR <= '0;
        end else if (state == S_WB) begin
            if (!ERR && (PERF_OPS != 16'hFFFF)) begin
                PERF_OPS <= PERF_OPS + 16'd1;
            end
            if (ERR && (PERF_ERR != 16'hFFFF)) begin
                PERF_ERR <= PERF_ERR + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a latency-accurate ALU stand-in plus a register-file/flags model.
module tb_alu_issue_ctrl;

    localparam int WIDTH   = 8;
    localparam int ALU_LAT = 2;

    logic             CLK;
    logic             RST_N;
    logic             IN_VALID;
    logic             IN_READY;
    logic [12:0]      INSTR;
    logic             LD_EN;
    logic [2:0]       LD_ADDR;
    logic [WIDTH-1:0] LD_DATA;
    logic [2:0]       RD_ADDR;
    logic [WIDTH-1:0] RD_DATA;
    logic             ALU_EN;
    logic             ALU_OE;
    logic [3:0]       ALU_OPCODE;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_RES;
    logic             ALU_CF;
    logic             ALU_OF;
    logic             ALU_SF;
    logic             ALU_ZF;
    logic             DONE;
    logic             ERR;
    logic [3:0]       FLAGS;
    logic             BUSY;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0]      PERF_OPS;
    logic [15:0]      PERF_ERR;
`endif

    alu_issue_ctrl #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .INSTR      (INSTR),
        .LD_EN      (LD_EN),
        .LD_ADDR    (LD_ADDR),
        .LD_DATA    (LD_DATA),
        .RD_ADDR    (RD_ADDR),
        .RD_DATA    (RD_DATA),
        .ALU_EN     (ALU_EN),
        .ALU_OE     (ALU_OE),
        .ALU_OPCODE (ALU_OPCODE),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_RES    (ALU_RES),
        .ALU_CF     (ALU_CF),
        .ALU_OF     (ALU_OF),
        .ALU_SF     (ALU_SF),
        .ALU_ZF     (ALU_ZF),
        .DONE       (DONE),
        .ERR        (ERR),
        .FLAGS      (FLAGS),
        .BUSY       (BUSY)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .PERF_OPS   (PERF_OPS),
        .PERF_ERR   (PERF_ERR)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_rf [8];
    logic [3:0]       m_flags;

    // Reference ALU behaviour: returns {CF, OF, SF, ZF, result}.
    function automatic logic [WIDTH+3:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             cf;
        logic             of;
        cf = 1'b0;
        of = 1'b0;
        s  = '0;
        case (op)
            4'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[WIDTH-1:0];
                cf = s[WIDTH];
                of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3: begin
                r  = a - b;
                cf = (a < b);
                of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd4:    r = a & b;
            4'd5:    r = a | b;
            4'd6:    r = a ^ b;
            4'd7:    r = ~a;
            default: r = '0;
        endcase
        return {cf, of, r[WIDTH-1], (r == '0), r};
    endfunction

    // ALU stand-in: result valid ALU_LAT edges after the edge that samples ALU_EN,
    // and only while ALU_OE is high; otherwise it presents random garbage.
    logic [ALU_LAT:0]   alu_v = '0;
    logic [WIDTH+3:0]   alu_q = '0;
    logic [WIDTH+3:0]   alu_junk = '0;

    always @(posedge CLK) begin
        alu_v    <= {alu_v[ALU_LAT-1:0], ALU_EN};
        alu_junk <= (WIDTH+4)'($urandom);
        if (ALU_EN) alu_q <= alu_f(ALU_OPCODE, ALU_A, ALU_B);
    end

    assign {ALU_CF, ALU_OF, ALU_SF, ALU_ZF, ALU_RES} =
        (alu_v[ALU_LAT] && ALU_OE) ? alu_q : alu_junk;

    task automatic load(input logic [2:0] addr, input logic [WIDTH-1:0] data);
        @(negedge CLK);
        LD_EN   = 1'b1;
        LD_ADDR = addr;
        LD_DATA = data;
        @(negedge CLK);
        LD_EN   = 1'b0;
        m_rf[addr] = data;
    endtask

    // Issue one instruction from IDLE and follow it through to writeback.
    task automatic run_op(input logic [3:0] op, input logic [2:0] d,
                          input logic [2:0] sa, input logic [2:0] sb, input string tag);
        logic [WIDTH+3:0] exp;
        logic             legal;
        int               done_k;
        int               en_cnt;
        int               exp_k;
        legal  = (op >= 4'd2) && (op <= 4'd7);
        exp    = alu_f(op, m_rf[sa], m_rf[sb]);
        exp_k  = legal ? 2 + ALU_LAT : 1;
        done_k = 0;
        en_cnt = 0;
        @(negedge CLK);
        IN_VALID = 1'b1;
        INSTR    = {op, d, sa, sb};
        #1;
        if (IN_READY !== 1'b1) begin n_err++; $display("FAIL %s ready_idle: got %b want 1", tag, IN_READY); end
        n_cmp++;
        @(negedge CLK);
        IN_VALID = 1'b0;
        INSTR    = 13'($urandom);
        for (int k = 1; k <= 20; k++) begin
            if (ALU_EN === 1'b1) begin
                en_cnt++;
                if ({ALU_OPCODE, ALU_A, ALU_B} !== {op, m_rf[sa], m_rf[sb]}) begin
                    n_err++;
                    $display("FAIL %s operands: got op=%h a=%h b=%h want op=%h a=%h b=%h",
                             tag, ALU_OPCODE, ALU_A, ALU_B, op, m_rf[sa], m_rf[sb]);
                end
                n_cmp++;
            end
            if (legal && k == 1) begin
                if ({ALU_EN, BUSY, IN_READY} !== 3'b110) begin
                    n_err++; $display("FAIL %s issue_cycle: got en/busy/rdy=%b want 110", tag, {ALU_EN, BUSY, IN_READY});
                end
                n_cmp++;
            end
            if (legal && k == 2) begin
                if ({ALU_EN, ALU_OE} !== 2'b01) begin
                    n_err++; $display("FAIL %s wait_en_oe: got %b want 01", tag, {ALU_EN, ALU_OE});
                end
                n_cmp++;
            end
            if (DONE === 1'b1) begin
                done_k = k;
                if (ERR !== !legal) begin n_err++; $display("FAIL %s err: got %b want %b", tag, ERR, !legal); end
                n_cmp++;
                break;
            end
            @(negedge CLK);
        end
        if (done_k !== exp_k) begin n_err++; $display("FAIL %s done_latency: got %0d want %0d", tag, done_k, exp_k); end
        n_cmp++;
        if (en_cnt !== (legal ? 1 : 0)) begin n_err++; $display("FAIL %s alu_en_pulses: got %0d want %0d", tag, en_cnt, legal ? 1 : 0); end
        n_cmp++;
        if (legal) begin
            m_rf[d] = exp[WIDTH-1:0];
            m_flags = exp[WIDTH+3:WIDTH];
        end
        @(negedge CLK);
        RD_ADDR = d;
        #1;
        if (RD_DATA !== m_rf[d]) begin n_err++; $display("FAIL %s rd_dst: got %h want %h", tag, RD_DATA, m_rf[d]); end
        n_cmp++;
        if (FLAGS !== m_flags) begin n_err++; $display("FAIL %s flags: got %b want %b", tag, FLAGS, m_flags); end
        n_cmp++;
        if ({DONE, ERR, BUSY, ALU_OE} !== 4'b0000) begin
            n_err++; $display("FAIL %s post_wb: got done/err/busy/oe=%b want 0000", tag, {DONE, ERR, BUSY, ALU_OE});
        end
        n_cmp++;
    endtask

    task automatic test_reset;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        INSTR    = '0;
        LD_EN    = 1'b0;
        LD_ADDR  = '0;
        LD_DATA  = '0;
        RD_ADDR  = 3'd4;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_flags = '0;
        repeat (3) @(negedge CLK);
        if ({ALU_EN, ALU_OE, DONE, ERR, BUSY} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got en/oe/done/err/busy=%b want 00000", {ALU_EN, ALU_OE, DONE, ERR, BUSY});
        end
        n_cmp++;
        if ({ALU_OPCODE, ALU_A, ALU_B, FLAGS} !== '0) begin
            n_err++; $display("FAIL reset_data: got op=%h a=%h b=%h flags=%b want 0", ALU_OPCODE, ALU_A, ALU_B, FLAGS);
        end
        n_cmp++;
        RST_N = 1'b1;
        @(negedge CLK);
        if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", IN_READY); end
        n_cmp++;
        if (RD_DATA !== m_rf[4]) begin n_err++; $display("FAIL reset_rf: got %h want %h", RD_DATA, m_rf[4]); end
        n_cmp++;
    endtask

    task automatic test_add;
        load(3'd1, 8'h05);
        load(3'd2, 8'h03);
        run_op(4'b0010, 3'd3, 3'd1, 3'd2, "add_basic");
    endtask

    task automatic test_overflow;
        load(3'd4, 8'h7F);
        load(3'd5, 8'h01);
        run_op(4'b0010, 3'd6, 3'd4, 3'd5, "add_overflow");
    endtask

    task automatic test_sub;
        run_op(4'b0011, 3'd7, 3'd1, 3'd1, "sub_zero");
        run_op(4'b0011, 3'd0, 3'd2, 3'd1, "sub_borrow");
    endtask

    task automatic test_illegal;
        run_op(4'b1111, 3'd3, 3'd4, 3'd5, "illegal_f");
        run_op(4'b0001, 3'd6, 3'd1, 3'd2, "illegal_1");
    endtask

    task automatic test_back_to_back;
        logic [12:0]      i1;
        logic [12:0]      i2;
        logic [WIDTH+3:0] e;
        logic [WIDTH-1:0] r1_keep;
        int accepts;
        int dones;
        int ens;
        int ready_bad;
        int d1;
        int a2;
        i1 = {4'd2, 3'd3, 3'd1, 3'd2};
        i2 = {4'd3, 3'd5, 3'd3, 3'd1};
        accepts = 0; dones = 0; ens = 0; ready_bad = 0; d1 = -1; a2 = -2;
        r1_keep = m_rf[1];
        LD_ADDR = 3'd1;
        LD_DATA = ~r1_keep;
        @(negedge CLK);
        IN_VALID = 1'b1;
        INSTR    = i1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            LD_EN = BUSY && !DONE;
            #1;
            if (ALU_EN === 1'b1) ens++;
            if (DONE === 1'b1) begin
                dones++;
                if (dones == 1) d1 = cyc;
            end
            if (BUSY && IN_READY) ready_bad++;
            if (IN_VALID && IN_READY) begin
                accepts++;
                if (accepts == 2) a2 = cyc;
            end
            if (dones == 2) break;
            @(negedge CLK);
            if (accepts == 1) INSTR = i2;
            if (accepts >= 2) IN_VALID = 1'b0;
        end
        IN_VALID = 1'b0;
        LD_EN    = 1'b0;
        e = alu_f(4'd2, m_rf[1], m_rf[2]);
        m_rf[3] = e[WIDTH-1:0];
        e = alu_f(4'd3, m_rf[3], m_rf[1]);
        m_rf[5] = e[WIDTH-1:0];
        m_flags = e[WIDTH+3:WIDTH];
        if (accepts !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", accepts); end
        n_cmp++;
        if (dones !== 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", dones); end
        n_cmp++;
        if (ens !== 2) begin n_err++; $display("FAIL b2b_alu_en: got %0d want 2", ens); end
        n_cmp++;
        if (ready_bad !== 0) begin n_err++; $display("FAIL b2b_ready_busy: got %0d cycles want 0", ready_bad); end
        n_cmp++;
        if (a2 !== d1 + 1) begin n_err++; $display("FAIL b2b_accept_slot: got cycle %0d want %0d", a2, d1 + 1); end
        n_cmp++;
        @(negedge CLK);
        for (int j = 0; j < 3; j++) begin
            logic [2:0] ra;
            ra = (j == 0) ? 3'd3 : (j == 1) ? 3'd5 : 3'd1;
            RD_ADDR = ra;
            #1;
            if (RD_DATA !== m_rf[ra]) begin n_err++; $display("FAIL b2b_rf R%0d: got %h want %h", ra, RD_DATA, m_rf[ra]); end
            n_cmp++;
        end
        if (FLAGS !== m_flags) begin n_err++; $display("FAIL b2b_flags: got %b want %b", FLAGS, m_flags); end
        n_cmp++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            logic [3:0] op;
            if ($urandom_range(0, 2) == 0) load(3'($urandom), WIDTH'($urandom));
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(2, 7));
            run_op(op, 3'($urandom), 3'($urandom), 3'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid;
        int spurious;
        spurious = 0;
        load(3'd1, 8'hA5);
        @(negedge CLK);
        IN_VALID = 1'b1;
        INSTR    = {4'd2, 3'd6, 3'd1, 3'd1};
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RD_ADDR = 3'd1;
        RST_N   = 1'b0;
        #1;
        if ({ALU_EN, ALU_OE, DONE, ERR, BUSY} !== 5'b0) begin
            n_err++; $display("FAIL rst_mid_ctrl: got en/oe/done/err/busy=%b want 00000", {ALU_EN, ALU_OE, DONE, ERR, BUSY});
        end
        n_cmp++;
        if ({ALU_OPCODE, ALU_A, ALU_B, FLAGS, RD_DATA} !== '0) begin
            n_err++; $display("FAIL rst_mid_data: got op=%h a=%h b=%h flags=%b rd=%h want 0",
                              ALU_OPCODE, ALU_A, ALU_B, FLAGS, RD_DATA);
        end
        n_cmp++;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_flags = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) spurious++;
        end
        if (spurious !== 0) begin n_err++; $display("FAIL rst_mid_done: got %0d pulses want 0", spurious); end
        n_cmp++;
        if ({IN_READY, BUSY} !== 2'b10) begin n_err++; $display("FAIL rst_mid_ready: got rdy/busy=%b want 10", {IN_READY, BUSY}); end
        n_cmp++;
        for (int i = 0; i < 8; i++) begin
            RD_ADDR = 3'(i);
            #1;
            if (RD_DATA !== m_rf[i]) begin n_err++; $display("FAIL rst_mid_rf R%0d: got %h want %h", i, RD_DATA, m_rf[i]); end
            n_cmp++;
        end
        run_op(4'b0010, 3'd2, 3'd1, 3'd1, "post_reset_add");
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
